// File: rtl/pd_mode_ctrl_if.sv
// rtl/pd_mode_ctrl_if.sv - detector/loop-filter side signals of the phase-detector mode sequencer
interface pd_mode_ctrl_if #(
  parameter int OUT_W = 8
);
  logic                    enable;
  logic signed [OUT_W-1:0] pd_out;
  logic                    bb_sel;
  logic [1:0]              gain_sel;
  logic                    locked;
  logic                    lock_lost;
  logic                    acq_timeout;
  logic [2:0]              state;

  modport master (
    output enable, pd_out,
    input  bb_sel, gain_sel, locked, lock_lost, acq_timeout, state
  );

  modport slave (
    input  enable, pd_out,
    output bb_sel, gain_sel, locked, lock_lost, acq_timeout, state
  );
endinterface

// File: rtl/pd_mode_ctrl.sv
// rtl/pd_mode_ctrl.sv - acquisition/tracking sequencer selecting detector mode and loop gain
module pd_mode_ctrl #(
  parameter int OUT_W       = 8,
  parameter int TDC_RANGE   = 64,
  parameter int LOCK_WIN    = 4,
  parameter int LOCK_CNT    = 32,
  parameter int FINE_CNT    = 64,
  parameter int SAT_CNT     = 4,
  parameter int BB_RUN      = 16,
  parameter int BLANK       = 2,
  parameter int ACQ_TIMEOUT = 4096
) (
  input  logic           refclk,
  input  logic           resetn,
  pd_mode_ctrl_if.slave  bus
);

  localparam int WIN_MAX = (LOCK_CNT > FINE_CNT) ? LOCK_CNT : FINE_CNT;
  localparam int WIN_W   = $clog2(WIN_MAX + 1);
  localparam int SAT_W   = $clog2(SAT_CNT + 1);
  localparam int RUN_W   = $clog2(BB_RUN + 1);
  localparam int BLK_W   = $clog2(BLANK + 1);
  localparam int TMR_W   = $clog2(ACQ_TIMEOUT);
  localparam int MAG_W   = OUT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACQ   = 3'd1,
    S_TRACK = 3'd2,
    S_FINE  = 3'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIN_W-1:0]   r_win_cnt, w_win_nxt, w_win_inc;
  logic [SAT_W-1:0]   r_sat_cnt, w_sat_nxt, w_sat_inc;
  logic [RUN_W-1:0]   r_run_cnt, w_run_nxt, w_run_inc;
  logic [BLK_W-1:0]   r_blank_cnt, w_blank_nxt;
  logic [TMR_W-1:0]   r_acq_tmr, w_tmr_nxt;
  logic               r_sign_vld, w_sign_vld_nxt;
  logic               r_sign_neg, w_sign_neg_nxt;
  logic               r_acq_timeout, w_timeout_nxt;
  logic               w_lost_nxt;
  logic               w_enter;
  logic               r_bb_sel, r_locked, r_lock_lost;
  logic [1:0]         r_gain_sel;

  logic signed [MAG_W-1:0] w_ext;
  logic [MAG_W-1:0]        w_mag;
  logic                    w_in_win, w_is_sat, w_neg, w_blanked;

  // Sign-extend by one bit so the most negative sample has a representable magnitude.
  assign w_ext     = {bus.pd_out[OUT_W-1], bus.pd_out};
  assign w_mag     = w_ext[MAG_W-1] ? MAG_W'(-w_ext) : MAG_W'(w_ext);
  assign w_in_win  = (w_mag <= MAG_W'(LOCK_WIN));
  assign w_is_sat  = (w_mag >= MAG_W'(TDC_RANGE));
  assign w_neg     = bus.pd_out[OUT_W-1];
  assign w_blanked = (r_blank_cnt != '0);

  assign w_win_inc = (r_win_cnt == WIN_W'(WIN_MAX)) ? r_win_cnt : r_win_cnt + WIN_W'(1);
  assign w_sat_inc = (r_sat_cnt == SAT_W'(SAT_CNT)) ? r_sat_cnt : r_sat_cnt + SAT_W'(1);
  assign w_run_inc = (r_run_cnt == RUN_W'(BB_RUN))  ? r_run_cnt : r_run_cnt + RUN_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_win_nxt      = r_win_cnt;
    w_sat_nxt      = r_sat_cnt;
    w_run_nxt      = r_run_cnt;
    w_sign_vld_nxt = r_sign_vld;
    w_sign_neg_nxt = r_sign_neg;
    w_blank_nxt    = r_blank_cnt;
    w_tmr_nxt      = r_acq_tmr;
    w_timeout_nxt  = r_acq_timeout;
    w_lost_nxt     = 1'b0;
    w_enter        = 1'b0;

    if (!bus.enable) begin
      w_state_nxt    = S_IDLE;
      w_win_nxt      = '0;
      w_sat_nxt      = '0;
      w_run_nxt      = '0;
      w_sign_vld_nxt = 1'b0;
      w_blank_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQ;
          w_tmr_nxt   = '0;
          w_enter     = 1'b1;
        end
        S_ACQ: begin
          if (w_blanked) begin
            w_blank_nxt = r_blank_cnt - BLK_W'(1);
          end else begin
            w_win_nxt = w_in_win ? w_win_inc : '0;
          end
          // A lock on the same sample as the timeout takes precedence.
          if (!w_blanked && w_in_win && (w_win_inc == WIN_W'(LOCK_CNT))) begin
            w_state_nxt = S_TRACK;
            w_enter     = 1'b1;
          end else if (r_acq_tmr == TMR_W'(ACQ_TIMEOUT - 1)) begin
            w_timeout_nxt = 1'b1;
            w_tmr_nxt     = '0;
            w_enter       = 1'b1;
          end else begin
            w_tmr_nxt = r_acq_tmr + TMR_W'(1);
          end
        end
        S_TRACK: begin
          if (w_blanked) begin
            w_blank_nxt = r_blank_cnt - BLK_W'(1);
          end else begin
            w_sat_nxt = w_is_sat ? w_sat_inc : '0;
            w_win_nxt = w_in_win ? w_win_inc : '0;
            if (w_is_sat && (w_sat_inc == SAT_W'(SAT_CNT))) begin
              w_state_nxt = S_ACQ;
              w_lost_nxt  = 1'b1;
              w_tmr_nxt   = '0;
              w_enter     = 1'b1;
            end else if (w_in_win && (w_win_inc == WIN_W'(FINE_CNT))) begin
              w_state_nxt = S_FINE;
              w_enter     = 1'b1;
            end
          end
        end
        S_FINE: begin
          if (w_blanked) begin
            w_blank_nxt = r_blank_cnt - BLK_W'(1);
          end else if (w_mag > MAG_W'(1)) begin
            w_state_nxt = S_ACQ;
            w_lost_nxt  = 1'b1;
            w_tmr_nxt   = '0;
            w_enter     = 1'b1;
          end else begin
            if (w_mag == '0) begin
              w_run_nxt      = '0;
              w_sign_vld_nxt = 1'b0;
            end else begin
              w_run_nxt      = (r_sign_vld && (r_sign_neg == w_neg)) ? w_run_inc : RUN_W'(1);
              w_sign_vld_nxt = 1'b1;
              w_sign_neg_nxt = w_neg;
            end
            if (w_run_nxt == RUN_W'(BB_RUN)) begin
              w_state_nxt = S_TRACK;
              w_enter     = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      // Every mode/gain change (including a timeout re-arm) restarts counting behind a blanking window.
      if (w_enter) begin
        w_win_nxt      = '0;
        w_sat_nxt      = '0;
        w_run_nxt      = '0;
        w_sign_vld_nxt = 1'b0;
        w_sign_neg_nxt = 1'b0;
        w_blank_nxt    = BLK_W'(BLANK);
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_win_cnt     <= '0;
      r_sat_cnt     <= '0;
      r_run_cnt     <= '0;
      r_blank_cnt   <= '0;
      r_acq_tmr     <= '0;
      r_sign_vld    <= 1'b0;
      r_sign_neg    <= 1'b0;
      r_acq_timeout <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_bb_sel      <= 1'b0;
      r_gain_sel    <= 2'd2;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_win_cnt     <= w_win_nxt;
      r_sat_cnt     <= w_sat_nxt;
      r_run_cnt     <= w_run_nxt;
      r_blank_cnt   <= w_blank_nxt;
      r_acq_tmr     <= w_tmr_nxt;
      r_sign_vld    <= w_sign_vld_nxt;
      r_sign_neg    <= w_sign_neg_nxt;
      r_acq_timeout <= w_timeout_nxt;
      r_lock_lost   <= w_lost_nxt;
      r_bb_sel      <= (w_state_nxt == S_FINE);
      r_locked      <= (w_state_nxt == S_TRACK) || (w_state_nxt == S_FINE);
      case (w_state_nxt)
        S_TRACK: r_gain_sel <= 2'd1;
        S_FINE:  r_gain_sel <= 2'd0;
        default: r_gain_sel <= 2'd2;
      endcase
    end
  end

  assign bus.state       = r_state;
  assign bus.bb_sel      = r_bb_sel;
  assign bus.gain_sel    = r_gain_sel;
  assign bus.locked      = r_locked;
  assign bus.lock_lost   = r_lock_lost;
  assign bus.acq_timeout = r_acq_timeout;

endmodule

// File: tb/tb_pd_mode_ctrl.sv
// tb/tb_pd_mode_ctrl.sv - directed self-checking bench for pd_mode_ctrl
module tb_pd_mode_ctrl;

  logic refclk;
  logic resetn;
  int   checks;
  int   failures;

  pd_mode_ctrl_if #(.OUT_W(8)) bus ();

  pd_mode_ctrl dut (
    .refclk (refclk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Inputs are applied before an edge; outputs are observed 1ns after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic test_reset();
    bit bad;
    resetn = 1'b0;
    bus.enable = 1'b0;
    bus.pd_out = 8'sd0;
    tick(3);
    resetn = 1'b1;
    checks++;
    if (bus.state !== 3'd0 || bus.bb_sel !== 1'b0 || bus.gain_sel !== 2'd2 ||
        bus.locked !== 1'b0 || bus.lock_lost !== 1'b0 || bus.acq_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: state=%0d bb=%0d gain=%0d locked=%0d lost=%0d tout=%0d expected 0/0/2/0/0/0",
               bus.state, bus.bb_sel, bus.gain_sel, bus.locked, bus.lock_lost, bus.acq_timeout);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.state !== 3'd0 || bus.bb_sel !== 1'b0 || bus.gain_sel !== 2'd2 || bus.locked !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_stable: state=%0d gain=%0d expected 0/2 for 20 cycles", bus.state, bus.gain_sel);
    end
  endtask

  task automatic test_acquisition();
    bus.enable = 1'b1;
    bus.pd_out = 8'sd3;
    tick(1);
    checks++;
    if (bus.state !== 3'd1 || bus.gain_sel !== 2'd2 || bus.locked !== 1'b0) begin
      failures++;
      $display("FAIL acq_entry: state=%0d gain=%0d locked=%0d expected 1/2/0", bus.state, bus.gain_sel, bus.locked);
    end
    tick(2 + 20);
    bus.pd_out = 8'sd5;
    tick(1);
    bus.pd_out = 8'sd3;
    tick(31);
    checks++;
    if (bus.state !== 3'd1 || bus.locked !== 1'b0) begin
      failures++;
      $display("FAIL acq_restart: state=%0d locked=%0d expected 1/0", bus.state, bus.locked);
    end
    tick(1);
    checks++;
    if (bus.state !== 3'd2 || bus.locked !== 1'b1 || bus.gain_sel !== 2'd1 || bus.bb_sel !== 1'b0) begin
      failures++;
      $display("FAIL acq_lock: state=%0d locked=%0d gain=%0d bb=%0d expected 2/1/1/0",
               bus.state, bus.locked, bus.gain_sel, bus.bb_sel);
    end
  endtask

  task automatic test_promotion_fallback();
    bit pulsed;
    pulsed = 1'b0;
    bus.pd_out = 8'sd0;
    for (int i = 0; i < 65; i++) begin
      tick(1);
      if (bus.lock_lost !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (bus.state !== 3'd2) begin
      failures++;
      $display("FAIL track_hold: state=%0d expected 2", bus.state);
    end
    tick(1);
    checks++;
    if (bus.state !== 3'd3 || bus.bb_sel !== 1'b1 || bus.gain_sel !== 2'd0 || bus.locked !== 1'b1) begin
      failures++;
      $display("FAIL fine_entry: state=%0d bb=%0d gain=%0d locked=%0d expected 3/1/0/1",
               bus.state, bus.bb_sel, bus.gain_sel, bus.locked);
    end
    bus.pd_out = 8'sd1;
    for (int i = 0; i < 17; i++) begin
      tick(1);
      if (bus.lock_lost !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (bus.state !== 3'd3) begin
      failures++;
      $display("FAIL fine_hold: state=%0d expected 3", bus.state);
    end
    tick(1);
    if (bus.lock_lost !== 1'b0) pulsed = 1'b1;
    checks++;
    if (bus.state !== 3'd2 || bus.bb_sel !== 1'b0 || bus.gain_sel !== 2'd1) begin
      failures++;
      $display("FAIL fine_fallback: state=%0d bb=%0d gain=%0d expected 2/0/1", bus.state, bus.bb_sel, bus.gain_sel);
    end
    checks++;
    if (pulsed) begin
      failures++;
      $display("FAIL fallback_no_lost: lock_lost=1 seen expected 0");
    end
  endtask

  task automatic test_loss_of_lock(input logic signed [7:0] sample, input bit relock);
    if (relock) begin
      bus.pd_out = 8'sd0;
      tick(1 + 32);
      checks++;
      if (bus.state !== 3'd2) begin
        failures++;
        $display("FAIL relock: state=%0d expected 2", bus.state);
      end
    end
    bus.pd_out = sample;
    tick(2 + 3);
    checks++;
    if (bus.state !== 3'd2 || bus.lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL sat_hold_%0d: state=%0d lost=%0d expected 2/0", sample, bus.state, bus.lock_lost);
    end
    tick(1);
    checks++;
    if (bus.state !== 3'd1 || bus.lock_lost !== 1'b1 || bus.locked !== 1'b0 || bus.gain_sel !== 2'd2) begin
      failures++;
      $display("FAIL sat_lost_%0d: state=%0d lost=%0d locked=%0d gain=%0d expected 1/1/0/2",
               sample, bus.state, bus.lock_lost, bus.locked, bus.gain_sel);
    end
    tick(1);
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL lost_one_cycle_%0d: lost=%0d expected 0", sample, bus.lock_lost);
    end
  endtask

  task automatic test_timeout();
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    bus.enable = 1'b1;
    bus.pd_out = 8'sd40;
    tick(1);
    tick(4095);
    checks++;
    if (bus.acq_timeout !== 1'b0 || bus.state !== 3'd1) begin
      failures++;
      $display("FAIL timeout_early: tout=%0d state=%0d expected 0/1", bus.acq_timeout, bus.state);
    end
    tick(1);
    checks++;
    if (bus.acq_timeout !== 1'b1 || bus.state !== 3'd1) begin
      failures++;
      $display("FAIL timeout_set: tout=%0d state=%0d expected 1/1", bus.acq_timeout, bus.state);
    end
    bus.pd_out = 8'sd0;
    tick(2 + 31);
    checks++;
    if (bus.state !== 3'd1 || bus.acq_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_reblank: state=%0d tout=%0d expected 1/1", bus.state, bus.acq_timeout);
    end
    tick(1);
    checks++;
    if (bus.state !== 3'd2 || bus.acq_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: state=%0d tout=%0d expected 2/1", bus.state, bus.acq_timeout);
    end
  endtask

  task automatic test_disruptions();
    bus.pd_out = 8'sd0;
    tick(2 + 64);
    checks++;
    if (bus.state !== 3'd3) begin
      failures++;
      $display("FAIL disr_fine: state=%0d expected 3", bus.state);
    end
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    checks++;
    if (bus.state !== 3'd0 || bus.bb_sel !== 1'b0 || bus.acq_timeout !== 1'b0 || bus.gain_sel !== 2'd2) begin
      failures++;
      $display("FAIL reset_in_fine: state=%0d bb=%0d tout=%0d gain=%0d expected 0/0/0/2",
               bus.state, bus.bb_sel, bus.acq_timeout, bus.gain_sel);
    end
    tick(1 + 2 + 32);
    checks++;
    if (bus.state !== 3'd2) begin
      failures++;
      $display("FAIL disr_track: state=%0d expected 2", bus.state);
    end
    bus.enable = 1'b0;
    tick(1);
    checks++;
    if (bus.state !== 3'd0 || bus.lock_lost !== 1'b0 || bus.locked !== 1'b0) begin
      failures++;
      $display("FAIL enable_drop: state=%0d lost=%0d locked=%0d expected 0/0/0", bus.state, bus.lock_lost, bus.locked);
    end
    bus.enable = 1'b1;
    tick(1 + 2 + 32);
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    tick(1);
    checks++;
    if (bus.state !== 3'd2 || bus.locked !== 1'b1) begin
      failures++;
      $display("FAIL reset_glitch: state=%0d locked=%0d expected 2/1", bus.state, bus.locked);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    bus.enable = 1'b0;
    bus.pd_out = 8'sd0;
    test_reset();
    test_acquisition();
    test_promotion_fallback();
    test_loss_of_lock(8'sd64, 1'b0);
    test_loss_of_lock(-8'sd128, 1'b1);
    test_timeout();
    test_disruptions();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
